// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: pops words and presents them as a valid/ready stream.
// Latency: first word valid 2 cycles after the first r_en; sustains 1 word/cycle thereafter.
// Backpressure: m_ready low holds m_valid/m_data stable; the credit rule on r_en keeps the 2-entry skid buffer from overflowing.
module fifo_rd_stream #(
    parameter int DATASIZE = 64,
    parameter int CNTSIZE  = 16
) (
    input  logic                rclk,
    input  logic                rrst_n,
    output logic                r_en,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    input  logic                m_ready,
    output logic [CNTSIZE-1:0]  rd_count,
    output logic                busy
);

    logic [1:0]          occ_q, occ_d;
    logic                pend_q;
    logic [DATASIZE-1:0] buf0_q, buf0_d;
    logic [DATASIZE-1:0] buf1_q, buf1_d;
    logic [CNTSIZE-1:0]  cnt_q, cnt_d;
    logic                pop_out;
    logic [2:0]          level;
    logic [1:0]          occ_post;

    assign pop_out = m_valid & m_ready;

    // Entries held or in flight once this cycle's pop is taken out; at most 2.
    assign level = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop_out};

    // Gated by reset so no pop can be issued while the read side is held in reset.
    assign r_en = rrst_n & ~rempty & (level < 3'd2);

    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        occ_post = occ_q - {1'b0, pop_out};
        if (pop_out) begin
            buf0_d = buf1_q;
        end
        // Capture lands at the tail after the pop shifts, so a capture with occ=1 and a pop goes straight to the head.
        if (pend_q) begin
            if (occ_post == 2'd0) begin
                buf0_d = rdata;
            end else begin
                buf1_d = rdata;
            end
        end
        occ_d = level[1:0];
        cnt_d = cnt_q + {{(CNTSIZE-1){1'b0}}, pop_out};
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
            buf0_q <= '0;
            buf1_q <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= r_en;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf0_q;
    assign rd_count = cnt_q;
    assign busy     = (occ_q != 2'd0) | pend_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO plus an in-order scoreboard of popped words.
module tb_fifo_rd_stream;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [63:0] rdata;
    logic        m_ready;
    logic        r_en, m_valid, busy;
    logic [63:0] m_data;
    logic [15:0] rd_count;
    logic        r_en4, m_valid4, busy4;
    logic [63:0] m_data4;
    logic [3:0]  rd_count4;

    always #5 rclk = ~rclk;

    fifo_rd_stream #(.DATASIZE(64), .CNTSIZE(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .r_en(r_en), .rempty(rempty), .rdata(rdata),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count), .busy(busy)
    );

    fifo_rd_stream #(.DATASIZE(64), .CNTSIZE(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .r_en(r_en4), .rempty(rempty), .rdata(rdata),
        .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .rd_count(rd_count4), .busy(busy4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] fifo_q[$];   // words written to the FIFO, not yet popped
    logic [63:0] flight_q[$]; // popped at the last edge, visible on rdata this cycle
    logic [63:0] cap_q[$];    // captured by the DUT, not yet delivered
    logic [63:0] got_q[$];    // words delivered since the last reset
    int delivered;
    int cyc;
    int ren_cnt, first_ren, first_vld, first_hs, last_hs;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        ren_cnt   = 0;
        first_ren = -1;
        first_vld = -1;
        first_hs  = -1;
        last_hs   = -1;
    endtask

    // One clock cycle; entered and left at the falling edge.
    task automatic run_cycle(input logic rdy);
        logic        pop_out, exp_ren, exp_vld, exp_busy;
        logic [63:0] w;
        w       = 64'd0;
        m_ready = rdy;
        rempty  = (fifo_q.size() == 0);
        #1;
        exp_vld  = (cap_q.size() != 0);
        pop_out  = exp_vld && rdy;
        exp_ren  = !rempty && ((cap_q.size() + flight_q.size() - int'(pop_out)) < 2);
        exp_busy = exp_vld || (flight_q.size() != 0);
        check_eq("m_valid", m_valid, exp_vld);
        if (exp_vld) check_eq("m_data", m_data, cap_q[0]);
        check_eq("r_en", r_en, exp_ren);
        check_eq("r_en_while_empty", r_en & rempty, 1'b0);
        check_eq("busy", busy, exp_busy);
        check_eq("rd_count", rd_count, delivered % 65536);
        check_eq("occ_bound", dut.occ_q <= 2'd2, 1'b1);
        check_eq("w4_m_valid", m_valid4, exp_vld);
        check_eq("w4_r_en", r_en4, exp_ren);
        check_eq("w4_busy", busy4, exp_busy);
        check_eq("w4_rd_count", rd_count4, delivered % 16);
        if (r_en) ren_cnt++;
        if (r_en && first_ren < 0) first_ren = cyc;
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (pop_out) begin
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        @(posedge rclk);
        if (pop_out) begin
            got_q.push_back(cap_q.pop_front());
            delivered++;
        end
        if (flight_q.size() != 0) cap_q.push_back(flight_q.pop_front());
        if (exp_ren) begin
            w = fifo_q.pop_front();
            flight_q.push_back(w);
        end
        #1;
        rdata = exp_ren ? w : {$urandom, $urandom};
        cyc++;
        @(negedge rclk);
    endtask

    task automatic do_reset();
        rrst_n  = 1'b0;
        rempty  = 1'b1;
        m_ready = 1'b0;
        fifo_q.delete();
        flight_q.delete();
        cap_q.delete();
        got_q.delete();
        delivered = 0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        clear_stats();
    endtask

    task automatic run_until(input int target, input logic rdy, input int limit);
        int guard;
        guard = 0;
        while (delivered < target && guard < limit) begin
            run_cycle(rdy);
            guard++;
        end
    endtask

    initial begin
        cyc     = 0;
        rdata   = 64'd0;
        rrst_n  = 1'b0;
        rempty  = 1'b0;
        m_ready = 1'b1;
        #2;
        check_eq("rst_r_en", r_en, 1'b0);
        check_eq("rst_m_valid", m_valid, 1'b0);
        check_eq("rst_m_data", m_data, 64'd0);
        check_eq("rst_rd_count", rd_count, 64'd0);
        check_eq("rst_busy", busy, 1'b0);
        @(negedge rclk);
        do_reset();

        // Streaming: words 0..7 with the sink always ready.
        for (int i = 0; i < 8; i++) fifo_q.push_back(64'(i));
        run_until(8, 1'b1, 20);
        repeat (2) run_cycle(1'b1);
        check_eq("s_delivered", delivered, 8);
        check_eq("s_rd_count", rd_count, 8);
        check_eq("s_busy_after", busy, 1'b0);
        check_eq("s_latency", first_vld - first_ren, 2);
        check_eq("s_back_to_back", last_hs - first_hs, 7);
        for (int i = 0; i < 8; i++) check_eq("s_order", got_q[i], 64'(i));

        // Backpressure: 5 words, sink stalled for 10 cycles.
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(64'h100 + 64'(i));
        repeat (10) run_cycle(1'b0);
        check_eq("bp_ren_count", ren_cnt, 2);
        check_eq("bp_occ", dut.occ_q, 2'd2);
        check_eq("bp_m_valid", m_valid, 1'b1);
        check_eq("bp_m_data", m_data, 64'h100);
        repeat (5) run_cycle(1'b1);
        check_eq("bp_drain_no_gap", delivered, 5);
        for (int i = 0; i < 5; i++) check_eq("bp_order", got_q[i], 64'h100 + 64'(i));

        // Random words, toggling then random sink readiness.
        begin
            int pushed, guard;
            do_reset();
            pushed = 0;
            guard  = 0;
            while (delivered < 100 && guard < 2000) begin
                if (pushed < 100 && $urandom_range(0, 3) != 0) begin
                    fifo_q.push_back({$urandom, $urandom});
                    pushed++;
                end
                if (guard < 200) run_cycle(guard[0] == 1'b0);
                else             run_cycle(1'($urandom_range(0, 1)));
                guard++;
            end
            check_eq("rand_delivered", delivered, 100);
        end

        // Single word: FIFO goes empty right after the pop.
        do_reset();
        fifo_q.push_back(64'hDEAD_BEEF);
        repeat (6) run_cycle(1'b1);
        check_eq("empty_delivered", delivered, 1);
        check_eq("empty_word", got_q[0], 64'hDEAD_BEEF);
        check_eq("empty_m_valid", m_valid, 1'b0);
        check_eq("empty_r_en", r_en, 1'b0);

        // Narrow counter wraps: 18 words -> 2.
        do_reset();
        for (int i = 0; i < 18; i++) fifo_q.push_back(64'h200 + 64'(i));
        run_until(18, 1'b1, 40);
        check_eq("wrap_delivered", delivered, 18);
        check_eq("wrap_rd_count4", rd_count4, 4'd2);
        check_eq("wrap_rd_count16", rd_count, 16'd18);

        // Reset with one word buffered and one in flight.
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(64'h300 + 64'(i));
        repeat (2) run_cycle(1'b0);
        check_eq("mid_occ", dut.occ_q, 2'd1);
        check_eq("mid_pend", dut.pend_q, 1'b1);
        #2;
        rrst_n = 1'b0;
        #1;
        check_eq("mid_rst_r_en", r_en, 1'b0);
        check_eq("mid_rst_m_valid", m_valid, 1'b0);
        check_eq("mid_rst_m_data", m_data, 64'd0);
        check_eq("mid_rst_rd_count", rd_count, 64'd0);
        check_eq("mid_rst_busy", busy, 1'b0);
        @(negedge rclk);
        do_reset();
        fifo_q.push_back(64'hA);
        fifo_q.push_back(64'hB);
        run_until(2, 1'b1, 20);
        repeat (4) run_cycle(1'b1);
        check_eq("post_rst_count", got_q.size(), 2);
        check_eq("post_rst_w0", got_q[0], 64'hA);
        check_eq("post_rst_w1", got_q[1], 64'hB);
        check_eq("post_rst_rd_count", rd_count, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
